// File: rtl/mul_sched_pkg.sv
// Shared types for the multiply-chain scheduler.
// Holds FSM states, tag record and the id-width helper.
package mul_sched_pkg;

    // Widest requester id the tag record must carry (N_REQ <= 8).
    localparam int ID_MAX_W = 3;

    // Index width for n requesters, never narrower than one bit.
    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic                valid;
        logic [ID_MAX_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Scans from ptr_i upward, wrapping, and grants the first request.
module rr_arbiter
    import mul_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IDW = id_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDW-1:0]   ptr_i,
    input  logic             en_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDW-1:0]   idx_o
);

    // First valid requester at or after the pointer wins.
    always_comb begin
        int   j;
        logic found;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(ptr_i) + k) % N_REQ;
            if (en_i && !found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/mul_chain_sched.sv
// Round-robin scheduler sharing one fixed-latency a*b*c chain.
// Issues one operand set per cycle and returns tagged results.
module mul_chain_sched
    import mul_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int OP_W  = 16,
    parameter int RES_W = 32,
    parameter int LAT   = 2,
    localparam int IDW  = id_w(N_REQ)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_REQ-1:0]  req_valid,
    output logic [N_REQ-1:0]  req_ready,
    input  logic [N_REQ*OP_W-1:0] req_a,
    input  logic [N_REQ*OP_W-1:0] req_b,
    input  logic [N_REQ*OP_W-1:0] req_c,
    input  logic              drain_req,
    output logic              drain_ack,
    output logic [OP_W-1:0]   mc_a,
    output logic [OP_W-1:0]   mc_b,
    output logic [OP_W-1:0]   mc_c,
    input  logic [RES_W-1:0]  mc_y,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [RES_W-1:0]  rsp_data,
    output logic              busy
);

    // One spare count so a full pipe plus the output stage never wraps.
    localparam int CNT_W = $clog2(LAT + 2);

    sched_state_t     state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [OP_W-1:0]  a_q, a_d;
    logic [OP_W-1:0]  b_q, b_d;
    logic [OP_W-1:0]  c_q, c_d;
    tag_t             tag_q [LAT];
    tag_t             tag_d;
    logic             rsp_valid_q;
    logic [IDW-1:0]   rsp_id_q;
    logic [CNT_W-1:0] inflight_q, inflight_d;

    logic             grant_en;
    logic [N_REQ-1:0] gnt;
    logic [IDW-1:0]   gidx;
    logic             fire;

    // Reset and a pending drain both suppress grants immediately.
    assign grant_en = reset_n && (state_q == RUN) && !drain_req;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .en_i  (grant_en),
        .gnt_o (gnt),
        .idx_o (gidx)
    );

    assign req_ready = gnt;
    assign fire      = |(req_valid & gnt);

    // Capture granted operands and advance the pointer past the winner.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        rr_ptr_d = rr_ptr_q;
        tag_d.valid = fire;
        tag_d.id    = ID_MAX_W'(gidx);
        if (fire) begin
            a_d = req_a[gidx*OP_W +: OP_W];
            b_d = req_b[gidx*OP_W +: OP_W];
            c_d = req_c[gidx*OP_W +: OP_W];
            if (gidx == IDW'(N_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = gidx + 1'b1;
            end
        end
    end

    // Issue/response balance of the chain.
    always_comb begin
        inflight_d = inflight_q;
        if (fire && !rsp_valid_q) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!fire && rsp_valid_q) begin
            inflight_d = inflight_q - 1'b1;
        end
    end

    // Drain FSM: stop issuing, wait for empty, hold until released.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (drain_req) state_d = DRAIN;
            end
            DRAIN: begin
                if (!drain_req) begin
                    state_d = RUN;
                end else if (inflight_q == '0) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!drain_req) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // Operand registers, pointer, FSM and in-flight counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            rr_ptr_q   <= '0;
            state_q    <= RUN;
            inflight_q <= '0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            rr_ptr_q   <= rr_ptr_d;
            state_q    <= state_d;
            inflight_q <= inflight_d;
        end
    end

    // Tag pipe lines each issue up with its chain result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            tag_q[0] <= tag_d;
            for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
            rsp_valid_q <= tag_q[LAT-1].valid;
            rsp_id_q    <= tag_q[LAT-1].id[IDW-1:0];
        end
    end

    assign mc_a      = a_q;
    assign mc_b      = b_q;
    assign mc_c      = c_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = mc_y;
    assign drain_ack = (state_q == HOLD);
    assign busy      = (inflight_q != '0);

endmodule
